// File: rtl/tinyriscv_pkg.sv
// Shared bus widths, prefetch depth and the FIFO entry layout for the instruction prefetcher.
package tinyriscv_pkg;

    localparam int unsigned InstBus       = 32;
    localparam int unsigned InstAddrBus   = 32;
    localparam int unsigned PrefetchDepth = 2;

    typedef logic [InstBus-1:0]     inst_t;
    typedef logic [InstAddrBus-1:0] inst_addr_t;

    typedef struct packed {
        inst_t      instr;
        inst_addr_t addr;
    } fetch_entry_t;

    function automatic inst_addr_t word_align(input inst_addr_t a);
        return a & ~inst_addr_t'(3);
    endfunction

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Synchronous FIFO holding fetched instruction words; pointers wrap modulo Depth (any Depth >= 2).
module fetch_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [Width-1:0]           data_i,
    output logic [Width-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_incr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = ptr_incr(wptr_q);
        end
        if (do_pop) begin
            rptr_d = ptr_incr(rptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: issues word reads under a credit limit, buffers in-order responses,
// and discards responses that were already in flight when a jump flushed the buffer.
module instr_prefetch
    import tinyriscv_pkg::*;
#(
    parameter int unsigned FifoDepth = PrefetchDepth
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   jtag_reset_flag_i,
    input  logic                   jump_flag_i,
    input  logic [InstAddrBus-1:0] jump_addr_i,
    output logic                   bus_req_o,
    output logic [InstAddrBus-1:0] bus_addr_o,
    input  logic                   bus_gnt_i,
    input  logic                   bus_rvalid_i,
    input  logic [InstBus-1:0]     bus_rdata_i,
    output logic [InstBus-1:0]     instr_o,
    output logic [InstAddrBus-1:0] instr_addr_o,
    output logic                   instr_ready_o,
    input  logic                   instr_consume_i
);

    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    logic            rst;
    inst_addr_t      jump_target;
    inst_addr_t      fetch_addr_q, fetch_addr_d;
    inst_addr_t      resp_addr_q, resp_addr_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] discard_q, discard_d;
    logic [CntW-1:0] fifo_count;
    logic [CntW:0]   credit_used;
    logic            req_accept, rsp_valid, push, pop;
    logic            fifo_full, fifo_empty;
    fetch_entry_t    push_entry, head_entry;

    assign rst         = rst_i | jtag_reset_flag_i;
    assign jump_target = word_align(jump_addr_i);

    // Reads still in flight hold a credit, so a response always finds room in the FIFO.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign bus_req_o   = !rst && !jump_flag_i && (credit_used < FifoDepth[CntW:0]);
    assign bus_addr_o  = fetch_addr_q;

    assign req_accept = bus_req_o & bus_gnt_i;
    assign rsp_valid  = bus_rvalid_i && (outstanding_q != '0);
    assign push       = rsp_valid && (discard_q == '0) && !jump_flag_i && !fifo_full;

    assign instr_ready_o = !fifo_empty && !jump_flag_i;
    assign pop           = instr_consume_i && instr_ready_o;
    assign instr_o       = fifo_empty ? '0 : head_entry.instr;
    assign instr_addr_o  = fifo_empty ? '0 : head_entry.addr;

    assign push_entry.instr = bus_rdata_i;
    assign push_entry.addr  = resp_addr_q;

    always_comb begin
        fetch_addr_d  = fetch_addr_q;
        resp_addr_d   = resp_addr_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CntW'(req_accept) - CntW'(rsp_valid);

        if (jump_flag_i) begin
            fetch_addr_d = jump_target;
        end else if (req_accept) begin
            fetch_addr_d = fetch_addr_q + inst_addr_t'(4);
        end

        if (jump_flag_i) begin
            resp_addr_d = jump_target;
        end else if (push) begin
            resp_addr_d = resp_addr_q + inst_addr_t'(4);
        end

        // Every read still pending after the jump edge belongs to the old stream.
        if (jump_flag_i) begin
            discard_d = outstanding_d;
        end else if (rsp_valid && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            fetch_addr_q  <= '0;
            resp_addr_q   <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            resp_addr_q   <= resp_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .Depth(FifoDepth),
        .Width($bits(fetch_entry_t))
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst),
        .clear_i(jump_flag_i),
        .push_i (push),
        .pop_i  (pop),
        .data_i (push_entry),
        .data_o (head_entry),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: a queue-based model of words buffered and reads in flight,
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_instr_prefetch;
    import tinyriscv_pkg::*;

    localparam int unsigned D = 2;

    logic        clk;
    logic        rst_i, jtag_reset_flag_i, jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic [31:0] instr_o, instr_addr_o;
    logic        instr_ready_o, instr_consume_i;

    instr_prefetch #(.FifoDepth(D)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .jtag_reset_flag_i(jtag_reset_flag_i),
        .jump_flag_i      (jump_flag_i),
        .jump_addr_i      (jump_addr_i),
        .bus_req_o        (bus_req_o),
        .bus_addr_o       (bus_addr_o),
        .bus_gnt_i        (bus_gnt_i),
        .bus_rvalid_i     (bus_rvalid_i),
        .bus_rdata_i      (bus_rdata_i),
        .instr_o          (instr_o),
        .instr_addr_o     (instr_addr_o),
        .instr_ready_o    (instr_ready_o),
        .instr_consume_i  (instr_consume_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; } rd_t;
    typedef struct { logic [31:0] data; logic [31:0] addr; } wd_t;

    rd_t         inflight[$];
    wd_t         words[$];
    logic [31:0] m_fetch = '0;
    logic [31:0] grant_log[$];
    logic [31:0] consume_log[$];
    int          total = 0;
    int          bad = 0;

    rd_t m_r;
    wd_t m_w;
    bit  m_req, m_rv, m_pop;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
    endfunction

    function automatic bit in_reset();
        return rst_i || jtag_reset_flag_i;
    endfunction

    function automatic bit exp_req();
        return !in_reset() && !jump_flag_i && ((words.size() + inflight.size()) < D);
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (inflight[i]) if (inflight[i].stale) n++;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on each rising edge from the inputs of the cycle just ended.
    always @(posedge clk) begin
        if (in_reset()) begin
            inflight.delete();
            words.delete();
            m_fetch = '0;
        end else begin
            m_req = exp_req();
            m_rv  = bus_rvalid_i && (inflight.size() > 0);
            m_pop = instr_consume_i && (words.size() > 0) && !jump_flag_i;
            if (m_pop) words.delete(0);
            if (m_rv) begin
                m_r = inflight.pop_front();
                if (!m_r.stale && !jump_flag_i) begin
                    m_w.data = bus_rdata_i;
                    m_w.addr = m_r.addr;
                    words.push_back(m_w);
                end
            end
            if (m_req && bus_gnt_i) begin
                m_r.addr  = m_fetch;
                m_r.stale = 1'b0;
                inflight.push_back(m_r);
                m_fetch = m_fetch + 32'd4;
            end
            if (jump_flag_i) begin
                words.delete();
                for (int i = 0; i < inflight.size(); i++) inflight[i].stale = 1'b1;
                m_fetch = jump_addr_i & 32'hFFFF_FFFC;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        check("bus_req", {31'b0, bus_req_o}, {31'b0, exp_req()});
        if (!in_reset()) begin
            check("bus_addr", bus_addr_o, m_fetch);
            check("ready", {31'b0, instr_ready_o}, {31'b0, (words.size() > 0) && !jump_flag_i});
            if ((words.size() > 0) && !jump_flag_i) begin
                check("instr", instr_o, words[0].data);
                check("instr_addr", instr_addr_o, words[0].addr);
            end
            check("outstanding", 32'(dut.outstanding_q), inflight.size());
            check("discard", 32'(dut.discard_q), stale_cnt());
            if (bus_req_o && bus_gnt_i) grant_log.push_back(bus_addr_o);
            if (instr_ready_o && instr_consume_i) consume_log.push_back(instr_addr_o);
        end
    end

    // rv: 0/1 literal, 2 = respond whenever a read is pending, 3 = random (incl. spurious).
    task automatic step(input bit r, input bit j, input bit jmp, input logic [31:0] ja,
                        input bit g, input int rv, input bit c);
        @(posedge clk);
        #1;
        rst_i             = r;
        jtag_reset_flag_i = j;
        jump_flag_i       = jmp;
        jump_addr_i       = ja;
        bus_gnt_i         = g;
        instr_consume_i   = c;
        case (rv)
            0:       bus_rvalid_i = 1'b0;
            1:       bus_rvalid_i = 1'b1;
            2:       bus_rvalid_i = (inflight.size() > 0);
            default: bus_rvalid_i = (inflight.size() > 0) ? ($urandom_range(0, 2) != 0)
                                                          : ($urandom_range(0, 7) == 0);
        endcase
        bus_rdata_i = (inflight.size() > 0) ? memfn(inflight[0].addr) : $urandom;
        #5;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        consume_log.delete();
    endtask

    bit          rr, rj, rjmp, rg, rc;
    logic [31:0] rja;

    initial begin
        rst_i = 1'b1; jtag_reset_flag_i = 1'b0; jump_flag_i = 1'b0; jump_addr_i = '0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0; instr_consume_i = 1'b0;

        // Reset state and streaming with consume always high.
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_req", {31'b0, bus_req_o}, 32'd0);
        step(1, 0, 0, 0, 0, 0, 0);
        clear_logs();
        step(0, 0, 0, 0, 1, 0, 1);
        check("rst_req_after", {31'b0, bus_req_o}, 32'd1);
        check("rst_addr", bus_addr_o, 32'h0);
        check("rst_ready", {31'b0, instr_ready_o}, 32'd0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_instr_addr", instr_addr_o, 32'h0);
        step(0, 0, 0, 0, 1, 2, 1);
        check("lat_ready_early", {31'b0, instr_ready_o}, 32'd0);
        step(0, 0, 0, 0, 1, 2, 1);
        check("lat_ready", {31'b0, instr_ready_o}, 32'd1);
        check("lat_instr_addr", instr_addr_o, 32'h0);
        check("lat_instr", instr_o, memfn(32'h0));
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, 2, 1);
        for (int i = 0; i < 4; i++) begin
            check("stream_grant", grant_log[i], 32'(4 * i));
            check("stream_consume", consume_log[i], 32'(4 * i));
        end

        // No consumption: two requests fill the FIFO and stop.
        step(1, 0, 0, 0, 0, 0, 0);
        clear_logs();
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 2, 0);
        check("full_ngrants", grant_log.size(), 32'd2);
        check("full_grant0", grant_log[0], 32'h0);
        check("full_grant1", grant_log[1], 32'h4);
        check("full_req", {31'b0, bus_req_o}, 32'd0);
        check("full_flag", {31'b0, dut.u_fifo.full_o}, 32'd1);
        check("full_head_addr", instr_addr_o, 32'h0);
        check("full_head", instr_o, memfn(32'h0));

        // Debug restart with a full FIFO.
        step(0, 1, 0, 0, 1, 0, 0);
        check("jtag_req", {31'b0, bus_req_o}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("jtag_ready", {31'b0, instr_ready_o}, 32'd0);
        check("jtag_addr", bus_addr_o, 32'h0);
        check("jtag_instr_addr", instr_addr_o, 32'h0);

        // Grant withheld.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            check("nognt_req", {31'b0, bus_req_o}, 32'd1);
            check("nognt_addr", bus_addr_o, 32'h0);
            check("nognt_ready", {31'b0, instr_ready_o}, 32'd0);
            check("nognt_outst", 32'(dut.outstanding_q), 32'd0);
        end

        // Jump to an unaligned target with two reads outstanding.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 32'h106, 1, 0, 0);
        check("jmp_req", {31'b0, bus_req_o}, 32'd0);
        clear_logs();
        step(0, 0, 0, 0, 1, 1, 0);
        check("jmp_addr", bus_addr_o, 32'h104);
        check("jmp_discard", 32'(dut.discard_q), 32'd2);
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 2, 0);
        check("jmp_stale_dropped", {31'b0, instr_ready_o}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("jmp_first_grant", grant_log[0], 32'h104);
        check("jmp_ready", {31'b0, instr_ready_o}, 32'd1);
        check("jmp_instr_addr", instr_addr_o, 32'h104);
        check("jmp_instr", instr_o, memfn(32'h104));

        // Jump together with a response: response retired, one read left to discard.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 32'h200, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        check("jrv_discard", 32'(dut.discard_q), 32'd1);
        check("jrv_outst", 32'(dut.outstanding_q), 32'd1);
        check("jrv_addr", bus_addr_o, 32'h200);

        // Jump, response and consume in the same cycle with a word buffered.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 32'h200, 1, 1, 1);
        check("jrc_ready_in_jump", {31'b0, instr_ready_o}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("jrc_ready", {31'b0, instr_ready_o}, 32'd0);
        check("jrc_empty", {31'b0, dut.u_fifo.empty_o}, 32'd1);
        check("jrc_discard", 32'(dut.discard_q), 32'd0);
        check("jrc_outst", 32'(dut.outstanding_q), 32'd0);
        check("jrc_addr", bus_addr_o, 32'h200);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            rr   = ($urandom_range(0, 255) == 0);
            rj   = ($urandom_range(0, 255) == 0);
            rjmp = ($urandom_range(0, 11) == 0);
            rja  = $urandom & 32'h0000_0FFF;
            rg   = ($urandom_range(0, 3) != 0);
            rc   = ($urandom_range(0, 1) != 0);
            step(rr, rj, rjmp, rja, rg, 3, rc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 SHALL have parameter FifoDepth, default 2, meaning instruction-word FIFO entries and maximum in-flight bus reads (legal 2..8).
REQ-002 SHALL have port clk_i, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port jtag_reset_flag_i, input, 1, debug restart, equivalent to rst_i.
REQ-005 SHALL have port jump_flag_i, input, 1, redirect/flush request.
REQ-006 SHALL have port jump_addr_i, input, InstAddrBus, redirect byte address.
REQ-007 SHALL have port bus_req_o, output, 1, instruction read request.
REQ-008 SHALL have port bus_addr_o, output, InstAddrBus, word-aligned read address.
REQ-009 SHALL have port bus_gnt_i, input, 1, request accepted.
REQ-010 SHALL have port bus_rvalid_i, input, 1, read data valid, in order.
REQ-011 SHALL have port bus_rdata_i, input, InstBus, read data.
REQ-012 SHALL have port instr_o, output, InstBus, FIFO head word to the fetch stage.
REQ-013 SHALL have port instr_addr_o, output, InstAddrBus, word address of instr_o.
REQ-014 SHALL have port instr_ready_o, output, 1, instr_o valid.
REQ-015 SHALL have port instr_consume_i, input, 1, fetch stage pops head word.

Function
REQ-016 Fetch address register SHALL load {jump_addr_i[31:2],2'b00} on jump, else +4 on each bus_req_o & bus_gnt_i.
REQ-017 bus_req_o SHALL be 1 iff fifo_count + outstanding < FifoDepth and jump_flag_i = 0 and not in reset.
REQ-018 bus_addr_o SHALL equal the fetch address register; bits [1:0] always 0.
REQ-019 Outstanding counter ($clog2(FifoDepth+1) bits) SHALL +1 on req&gnt, -1 on rvalid, hold when both.
REQ-020 bus_rvalid_i with outstanding = 0 SHALL be ignored.
REQ-021 On jump_flag_i: FIFO cleared that cycle; discard counter := outstanding + (req&gnt) - rvalid, i.e. all reads in flight after the edge.
REQ-022 While discard > 0, each rvalid SHALL decrement discard and SHALL NOT push.
REQ-023 Otherwise rvalid SHALL push {bus_rdata_i, response address}; response address counter loaded like REQ-016, +4 per accepted push.
REQ-024 Credit rule (REQ-017) guarantees no push when full; push when full SHALL never occur.
REQ-025 instr_ready_o = FIFO not empty and jump_flag_i = 0.
REQ-026 Pop SHALL occur iff instr_consume_i & instr_ready_o; consume when empty ignored.
REQ-027 Simultaneous push and pop SHALL keep count, both take effect.
REQ-028 Latency: jump at edge T, gnt at T+1, rvalid at T+2 -> instr_ready_o = 1 in cycle T+3.
REQ-029 Jump simultaneous with rvalid/consume: flush wins; rvalid counted as retired, not pushed.
REQ-030 FIFO pointers SHALL wrap modulo FifoDepth.

Reset
REQ-031 On rst_i or jtag_reset_flag_i: fetch and response addresses 0, FIFO empty, outstanding 0, discard 0, bus_req_o 0, instr_ready_o 0, instr_o 0, instr_addr_o 0.
REQ-032 Reset mid-transaction SHALL drop in-flight state; the bus is reset together with this block.

Structure
REQ-033 InstBus, InstAddrBus, PrefetchDepth SHALL live in tinyriscv_pkg.
REQ-034 Storage SHALL be one sub-module, fetch_fifo (sync FIFO, parameter depth/width, push/pop/full/empty/count).

Verification
REQ-035 Reset then gnt always 1, rvalid one cycle later, consume always 1 -> bus_addr_o 0,4,8,...; instr_addr_o matches each word.
REQ-036 instr_consume_i held 0 -> exactly 2 requests (0x0,0x4), bus_req_o stays 0, FIFO full holds 0x0 at head.
REQ-037 Jump to 0x106 with 2 reads outstanding -> next request 0x104, both stale rvalids dropped, first instr_addr_o = 0x104.
REQ-038 bus_gnt_i held 0 for 5 cycles -> bus_req_o and bus_addr_o stable, outstanding 0, instr_ready_o 0.
REQ-039 jtag_reset_flag_i pulse with FIFO full -> next cycle instr_ready_o 0, bus_addr_o 0x0.
REQ-040 Jump, rvalid and consume in same cycle -> FIFO empty next cycle, discard = remaining in-flight count.
